// File: rtl/mem_controller_pkg.sv
// Shared types and default widths for the data-memory controller and its arbiter.
package mem_controller_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_WAIT  = 2'd1,
      WRITE_WAIT = 2'd2,
      RELEASE    = 2'd3
   } state_t;

   localparam int DEFAULT_NUM_CONSUMERS  = 4;
   localparam int DEFAULT_ADDR_BITS      = 8;
   localparam int DEFAULT_DATA_BITS      = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   // Width of an index able to address n items; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_controller_rr_arbiter.sv
// Rotating-priority pick: scans the request vector starting at the pointer,
// wrapping around, and reports the first requester found.
module rr_arbiter
   import mem_controller_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]              request,
   input  logic [idx_width(N)-1:0]   pointer,
   output logic [idx_width(N)-1:0]   grant,
   output logic                      found
);

   localparam int IW = idx_width(N);

   int idx;

   // Walk the requesters in pointer order and keep the first one that is asking.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(pointer) + i) % N;
         if (!found && request[idx]) begin
            grant = IW'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_controller.sv
// Shares one data-memory port among several LSU requesters, one transaction
// at a time, with round-robin arbitration and 4-phase handshakes on both sides.
// Optional watchdog: define MEM_CONTROLLER_TIMEOUT_EN to add consumer_error and
// abort memory accesses that never complete.
module mem_controller
   import mem_controller_pkg::*;
#(
   parameter int NUM_CONSUMERS  = DEFAULT_NUM_CONSUMERS,
   parameter int ADDR_BITS      = DEFAULT_ADDR_BITS,
   parameter int DATA_BITS      = DEFAULT_DATA_BITS
`ifdef MEM_CONTROLLER_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_address,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data,
   output logic                               mem_write_valid,
   output logic [ADDR_BITS-1:0]               mem_write_address,
   output logic [DATA_BITS-1:0]               mem_write_data,
   input  logic                               mem_write_ready,
`ifdef MEM_CONTROLLER_TIMEOUT_EN
   output logic [NUM_CONSUMERS-1:0]           consumer_error,
`endif
   output logic                               busy
);

   localparam int IW = idx_width(NUM_CONSUMERS);

   state_t                  state_q, state_d;
   logic [IW-1:0]           grant_q, grant_d;
   logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [NUM_CONSUMERS-1:0] read_ready_d, write_ready_d;
   logic                    mem_read_valid_d, mem_write_valid_d;
   logic [ADDR_BITS-1:0]    mem_read_address_d, mem_write_address_d;
   logic [DATA_BITS-1:0]    mem_write_data_d;
   logic                    serviced_valid;

   logic [ADDR_BITS-1:0]    rd_addr [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0]    wr_addr [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]    wr_data [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]    rd_data_q [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]    rd_data_d [NUM_CONSUMERS];

   logic [NUM_CONSUMERS-1:0] candidates;
   logic [IW-1:0]           arb_grant;
   logic                    arb_found;

`ifdef MEM_CONTROLLER_TIMEOUT_EN
   localparam int CW = idx_width(TIMEOUT_CYCLES);
   logic [CW-1:0]           count_q, count_d;
   logic [NUM_CONSUMERS-1:0] error_d;
`endif

   // Packed buses are viewed as per-consumer arrays so the granted slice is a plain index.
   for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_slices
      assign rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
      assign wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
      assign wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
      assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = rd_data_q[i];
   end

   assign candidates = consumer_read_valid | consumer_write_valid;
   assign busy       = (state_q != IDLE);

   rr_arbiter #(.N(NUM_CONSUMERS)) u_arbiter (
      .request (candidates),
      .pointer (rr_ptr_q),
      .grant   (arb_grant),
      .found   (arb_found)
   );

   // Next-state and next-output decode; every register holds unless a state acts on it.
   always_comb begin
      state_d             = state_q;
      grant_d             = grant_q;
      rr_ptr_d            = rr_ptr_q;
      read_ready_d        = consumer_read_ready;
      write_ready_d       = consumer_write_ready;
      rd_data_d           = rd_data_q;
      mem_read_valid_d    = mem_read_valid;
      mem_read_address_d  = mem_read_address;
      mem_write_valid_d   = mem_write_valid;
      mem_write_address_d = mem_write_address;
      mem_write_data_d    = mem_write_data;
      serviced_valid      = 1'b0;
`ifdef MEM_CONTROLLER_TIMEOUT_EN
      count_d             = count_q;
      error_d             = consumer_error;
`endif
      unique case (state_q)
         IDLE: begin
            if (arb_found) begin
               grant_d = arb_grant;
`ifdef MEM_CONTROLLER_TIMEOUT_EN
               count_d = '0;
`endif
               if (consumer_read_valid[arb_grant]) begin
                  mem_read_valid_d   = 1'b1;
                  mem_read_address_d = rd_addr[arb_grant];
                  state_d            = READ_WAIT;
               end else begin
                  mem_write_valid_d   = 1'b1;
                  mem_write_address_d = wr_addr[arb_grant];
                  mem_write_data_d    = wr_data[arb_grant];
                  state_d             = WRITE_WAIT;
               end
            end
         end
         READ_WAIT: begin
            if (mem_read_ready) begin
               mem_read_valid_d       = 1'b0;
               rd_data_d[grant_q]     = mem_read_data;
               read_ready_d[grant_q]  = 1'b1;
               state_d                = RELEASE;
            end
`ifdef MEM_CONTROLLER_TIMEOUT_EN
            else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
               mem_read_valid_d      = 1'b0;
               rd_data_d[grant_q]    = '0;
               read_ready_d[grant_q] = 1'b1;
               error_d[grant_q]      = 1'b1;
               state_d               = RELEASE;
            end else begin
               count_d = count_q + 1'b1;
            end
`endif
         end
         WRITE_WAIT: begin
            if (mem_write_ready) begin
               mem_write_valid_d      = 1'b0;
               write_ready_d[grant_q] = 1'b1;
               state_d                = RELEASE;
            end
`ifdef MEM_CONTROLLER_TIMEOUT_EN
            else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
               mem_write_valid_d      = 1'b0;
               write_ready_d[grant_q] = 1'b1;
               error_d[grant_q]       = 1'b1;
               state_d                = RELEASE;
            end else begin
               count_d = count_q + 1'b1;
            end
`endif
         end
         RELEASE: begin
            serviced_valid = consumer_read_ready[grant_q] ? consumer_read_valid[grant_q]
                                                          : consumer_write_valid[grant_q];
            if (!serviced_valid) begin
               read_ready_d  = '0;
               write_ready_d = '0;
`ifdef MEM_CONTROLLER_TIMEOUT_EN
               error_d       = '0;
`endif
               rr_ptr_d      = (grant_q == IW'(NUM_CONSUMERS - 1)) ? '0 : grant_q + 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any in-flight access at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q              <= IDLE;
         grant_q              <= '0;
         rr_ptr_q             <= '0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         rd_data_q            <= '{default: '0};
         mem_read_valid       <= 1'b0;
         mem_read_address     <= '0;
         mem_write_valid      <= 1'b0;
         mem_write_address    <= '0;
         mem_write_data       <= '0;
`ifdef MEM_CONTROLLER_TIMEOUT_EN
         count_q              <= '0;
         consumer_error       <= '0;
`endif
      end else begin
         state_q              <= state_d;
         grant_q              <= grant_d;
         rr_ptr_q             <= rr_ptr_d;
         consumer_read_ready  <= read_ready_d;
         consumer_write_ready <= write_ready_d;
         rd_data_q            <= rd_data_d;
         mem_read_valid       <= mem_read_valid_d;
         mem_read_address     <= mem_read_address_d;
         mem_write_valid      <= mem_write_valid_d;
         mem_write_address    <= mem_write_address_d;
         mem_write_data       <= mem_write_data_d;
`ifdef MEM_CONTROLLER_TIMEOUT_EN
         count_q              <= count_d;
         consumer_error       <= error_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: stimulus pushes expected memory and
// consumer transactions, independent monitors pop and compare them.
module tb_mem_controller;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;

   logic            clk;
   logic            reset;
   logic [N-1:0]    consumer_read_valid;
   logic [N*AW-1:0] consumer_read_address;
   logic [N-1:0]    consumer_read_ready;
   logic [N*DW-1:0] consumer_read_data;
   logic [N-1:0]    consumer_write_valid;
   logic [N*AW-1:0] consumer_write_address;
   logic [N*DW-1:0] consumer_write_data;
   logic [N-1:0]    consumer_write_ready;
   logic            mem_read_valid;
   logic [AW-1:0]   mem_read_address;
   logic            mem_read_ready;
   logic [DW-1:0]   mem_read_data;
   logic            mem_write_valid;
   logic [AW-1:0]   mem_write_address;
   logic [DW-1:0]   mem_write_data;
   logic            mem_write_ready;
   logic            busy;
`ifdef MEM_CONTROLLER_TIMEOUT_EN
   logic [N-1:0]    consumer_error;
`endif

   mem_controller #(
      .NUM_CONSUMERS (N),
      .ADDR_BITS     (AW),
      .DATA_BITS     (DW)
`ifdef MEM_CONTROLLER_TIMEOUT_EN
      , .TIMEOUT_CYCLES (8)
`endif
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .consumer_read_valid    (consumer_read_valid),
      .consumer_read_address  (consumer_read_address),
      .consumer_read_ready    (consumer_read_ready),
      .consumer_read_data     (consumer_read_data),
      .consumer_write_valid   (consumer_write_valid),
      .consumer_write_address (consumer_write_address),
      .consumer_write_data    (consumer_write_data),
      .consumer_write_ready   (consumer_write_ready),
      .mem_read_valid         (mem_read_valid),
      .mem_read_address       (mem_read_address),
      .mem_read_ready         (mem_read_ready),
      .mem_read_data          (mem_read_data),
      .mem_write_valid        (mem_write_valid),
      .mem_write_address      (mem_write_address),
      .mem_write_data         (mem_write_data),
      .mem_write_ready        (mem_write_ready),
`ifdef MEM_CONTROLLER_TIMEOUT_EN
      .consumer_error         (consumer_error),
`endif
      .busy                   (busy)
   );

   typedef struct {
      bit         is_write;
      logic [7:0] addr;
      logic [7:0] data;
   } mem_txn_t;

   typedef struct {
      int         idx;
      bit         is_write;
      logic [7:0] data;
      bit         err;
   } cons_txn_t;

   mem_txn_t   mem_exp_q[$];
   cons_txn_t  cons_exp_q[$];
   int         tests_run = 0;
   int         tests_failed = 0;
   logic [7:0] mem_array [256];
   int         mem_delay = 1;
   bit         mem_never = 1'b0;
   int         mem_wait = 0;

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushMem(input bit is_write, input logic [7:0] addr, input logic [7:0] data);
      mem_txn_t t;
      t.is_write = is_write;
      t.addr     = addr;
      t.data     = data;
      mem_exp_q.push_back(t);
   endtask

   task automatic pushCons(input int idx, input bit is_write, input logic [7:0] data, input bit err);
      cons_txn_t t;
      t.idx      = idx;
      t.is_write = is_write;
      t.data     = data;
      t.err      = err;
      cons_exp_q.push_back(t);
   endtask

   // One clock: step #1 past the edge, then run the memory model and the consumer 4-phase agents.
   task automatic tick();
      @(posedge clk);
      #1;
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = 8'hEE;
      if (mem_read_valid || mem_write_valid) begin
         mem_wait++;
         if (!mem_never && mem_wait >= mem_delay) begin
            mem_wait = 0;
            if (mem_read_valid) begin
               mem_read_data  = mem_array[mem_read_address];
               mem_read_ready = 1'b1;
            end else begin
               mem_array[mem_write_address] = mem_write_data;
               mem_write_ready = 1'b1;
            end
         end
      end else begin
         mem_wait = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (consumer_read_ready[i] && consumer_read_valid[i]) consumer_read_valid[i] = 1'b0;
         if (consumer_write_ready[i] && consumer_write_valid[i]) consumer_write_valid[i] = 1'b0;
      end
   endtask

   task automatic applyStimulus(input int idx, input bit is_write, input logic [7:0] addr, input logic [7:0] data);
      if (is_write) begin
         consumer_write_address[idx*AW +: AW] = addr;
         consumer_write_data[idx*DW +: DW]    = data;
         consumer_write_valid[idx]            = 1'b1;
      end else begin
         consumer_read_address[idx*AW +: AW] = addr;
         consumer_read_valid[idx]            = 1'b1;
      end
   endtask

   task automatic waitIdle(input string name, input int budget);
      int cycles = 0;
      while (!(busy == 1'b0 && consumer_read_valid == '0 && consumer_write_valid == '0
               && cons_exp_q.size() == 0)) begin
         tick();
         cycles++;
         if (cycles > budget) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: still busy after %0d cycles, expected idle", name, budget);
            break;
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " mem_read_valid"}, 32'(mem_read_valid), 0);
      checkOutput({tag, " mem_write_valid"}, 32'(mem_write_valid), 0);
      checkOutput({tag, " mem_read_address"}, 32'(mem_read_address), 0);
      checkOutput({tag, " mem_write_address"}, 32'(mem_write_address), 0);
      checkOutput({tag, " mem_write_data"}, 32'(mem_write_data), 0);
      checkOutput({tag, " consumer_read_ready"}, 32'(consumer_read_ready), 0);
      checkOutput({tag, " consumer_write_ready"}, 32'(consumer_write_ready), 0);
      checkOutput({tag, " consumer_read_data"}, 32'(consumer_read_data), 0);
      checkOutput({tag, " busy"}, 32'(busy), 0);
`ifdef MEM_CONTROLLER_TIMEOUT_EN
      checkOutput({tag, " consumer_error"}, 32'(consumer_error), 0);
`endif
   endtask

   logic       prev_mrv = 1'b0;
   logic       prev_mwv = 1'b0;
   logic [7:0] held_addr = '0;
   logic [7:0] held_data = '0;

   // Memory-side monitor: each new memory request is matched against the next expected access.
   always @(negedge clk) begin
      mem_txn_t   t;
      logic [7:0] addr;
      addr = mem_write_valid ? mem_write_address : mem_read_address;
      if ((mem_read_valid && !prev_mrv) || (mem_write_valid && !prev_mwv)) begin
         checkOutput("mem valids exclusive", 32'(mem_read_valid & mem_write_valid), 0);
         if (mem_exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL mem unexpected: got request at 0x%0h, expected none", addr);
         end else begin
            t = mem_exp_q.pop_front();
            checkOutput("mem op is_write", 32'(mem_write_valid), 32'(t.is_write));
            checkOutput("mem address", 32'(addr), 32'(t.addr));
            if (t.is_write) checkOutput("mem write data", 32'(mem_write_data), 32'(t.data));
         end
         held_addr = addr;
         held_data = mem_write_data;
      end else if (mem_read_valid || mem_write_valid) begin
         checkOutput("mem address hold", 32'(addr), 32'(held_addr));
         if (mem_write_valid) checkOutput("mem data hold", 32'(mem_write_data), 32'(held_data));
      end
      prev_mrv = mem_read_valid;
      prev_mwv = mem_write_valid;
   end

   logic [N-1:0] prev_rr = '0;
   logic [N-1:0] prev_wr = '0;

   // Consumer-side monitor: each rising ready is matched against the next expected completion.
   always @(negedge clk) begin
      cons_txn_t t;
      for (int i = 0; i < N; i++) begin
         if ((consumer_read_ready[i] && !prev_rr[i]) || (consumer_write_ready[i] && !prev_wr[i])) begin
            checkOutput("ready one-hot", 32'($countones({consumer_read_ready, consumer_write_ready})), 1);
            if (cons_exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL consumer unexpected: got ready on %0d, expected none", i);
            end else begin
               t = cons_exp_q.pop_front();
               checkOutput("consumer index", i, t.idx);
               checkOutput("consumer op is_write", 32'(consumer_write_ready[i]), 32'(t.is_write));
               if (!t.is_write)
                  checkOutput("consumer read data", 32'(consumer_read_data[i*DW +: DW]), 32'(t.data));
`ifdef MEM_CONTROLLER_TIMEOUT_EN
               checkOutput("consumer error", 32'(consumer_error[i]), 32'(t.err));
`endif
            end
         end
      end
      prev_rr = consumer_read_ready;
      prev_wr = consumer_write_ready;
   end

   // Global guard so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios in order; the round-robin pointer carries over between them.
   initial begin
      int n;
      reset = 1'b1;
      consumer_read_valid    = '0;
      consumer_read_address  = '0;
      consumer_write_valid   = '0;
      consumer_write_address = '0;
      consumer_write_data    = '0;
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = '0;
      for (int i = 0; i < 256; i++) mem_array[i] = 8'h00;
      mem_array[8'h1A] = 8'h5C;
      mem_array[8'h40] = 8'h11; mem_array[8'h41] = 8'h22;
      mem_array[8'h42] = 8'h33; mem_array[8'h43] = 8'h44;
      mem_array[8'h10] = 8'hA1; mem_array[8'h11] = 8'hB2;
      mem_array[8'h13] = 8'hC3; mem_array[8'h14] = 8'hD4;
      mem_array[8'h04] = 8'h3E; mem_array[8'h60] = 8'h9E;
      mem_array[8'h70] = 8'h66;

      #2 reset = 1'b0;
      #2 checkAllZero("reset");
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Single read from consumer 2 with a 3-cycle memory.
      mem_delay = 3;
      pushMem(1'b0, 8'h1A, 8'h00);
      pushCons(2, 1'b0, 8'h5C, 1'b0);
      applyStimulus(2, 1'b0, 8'h1A, 8'h00);
      tick();
      checkOutput("single read latency", 32'(mem_read_valid), 1);
      waitIdle("single read", 100);
      checkOutput("single read busy after", 32'(busy), 0);
      checkOutput("single read ready after", 32'(consumer_read_ready[2]), 0);
      checkOutput("single read data retained", 32'(consumer_read_data[2*DW +: DW]), 32'h5C);

      // Pointer at 3: consumer 3 writes, then everybody reads; grant wraps to 0. Slow memory.
      mem_delay = 5;
      pushMem(1'b1, 8'h33, 8'hA5);
      pushCons(3, 1'b1, 8'h00, 1'b0);
      applyStimulus(3, 1'b1, 8'h33, 8'hA5);
      tick();
      checkOutput("wrap write granted", 32'(mem_write_valid), 1);
      for (int i = 0; i < N; i++) begin
         pushMem(1'b0, 8'(8'h40 + i), 8'h00);
         pushCons(i, 1'b0, mem_array[8'(8'h40 + i)], 1'b0);
         applyStimulus(i, 1'b0, 8'(8'h40 + i), 8'h00);
      end
      waitIdle("wrap", 300);
      checkOutput("wrap write stored", 32'(mem_array[8'h33]), 32'hA5);

      // Pointer at 0: consumers 0,1,3 read; 0 re-requests while 1 and 3 pend.
      mem_delay = 1;
      pushMem(1'b0, 8'h10, 0); pushCons(0, 1'b0, 8'hA1, 1'b0);
      pushMem(1'b0, 8'h11, 0); pushCons(1, 1'b0, 8'hB2, 1'b0);
      pushMem(1'b0, 8'h13, 0); pushCons(3, 1'b0, 8'hC3, 1'b0);
      pushMem(1'b0, 8'h14, 0); pushCons(0, 1'b0, 8'hD4, 1'b0);
      applyStimulus(0, 1'b0, 8'h10, 0);
      applyStimulus(1, 1'b0, 8'h11, 0);
      applyStimulus(3, 1'b0, 8'h13, 0);
      n = 0;
      while (consumer_read_valid[0] && n < 50) begin
         tick();
         n++;
      end
      tick();
      applyStimulus(0, 1'b0, 8'h14, 0);
      waitIdle("round robin", 200);

      // Consumer 1 read and write together: read goes first.
      pushMem(1'b0, 8'h04, 0);     pushCons(1, 1'b0, 8'h3E, 1'b0);
      pushMem(1'b1, 8'h08, 8'h77); pushCons(1, 1'b1, 8'h00, 1'b0);
      applyStimulus(1, 1'b0, 8'h04, 0);
      applyStimulus(1, 1'b1, 8'h08, 8'h77);
      waitIdle("read+write", 100);
      checkOutput("read+write stored", 32'(mem_array[8'h08]), 32'h77);
      checkOutput("other slice untouched", 32'(consumer_read_data[2*DW +: DW]), 32'h33);

      // Asynchronous reset in READ_WAIT; afterwards the pointer is back at 0.
      mem_never = 1'b1;
      pushMem(1'b0, 8'h50, 0);
      applyStimulus(2, 1'b0, 8'h50, 0);
      applyStimulus(0, 1'b0, 8'h60, 0);
      applyStimulus(3, 1'b0, 8'h13, 0);
      tick();
      tick();
      checkOutput("pre-reset busy", 32'(busy), 1);
      #3 reset = 1'b0;
      #1 checkAllZero("async reset");
      consumer_read_valid[2] = 1'b0;
      mem_never = 1'b0;
      mem_delay = 1;
      pushMem(1'b0, 8'h60, 0); pushCons(0, 1'b0, 8'h9E, 1'b0);
      pushMem(1'b0, 8'h13, 0); pushCons(3, 1'b0, 8'hC3, 1'b0);
      #2 reset = 1'b1;
      waitIdle("after reset", 100);

`ifdef MEM_CONTROLLER_TIMEOUT_EN
      // Watchdog: a good read, then a read the memory never answers.
      pushMem(1'b0, 8'h70, 0); pushCons(1, 1'b0, 8'h66, 1'b0);
      applyStimulus(1, 1'b0, 8'h70, 0);
      waitIdle("pre-timeout read", 100);
      mem_never = 1'b1;
      pushMem(1'b0, 8'h71, 0); pushCons(1, 1'b0, 8'h00, 1'b1);
      applyStimulus(1, 1'b0, 8'h71, 0);
      tick();
      n = 0;
      while (!consumer_read_ready[1] && n < 100) begin
         tick();
         n++;
      end
      checkOutput("timeout cycles in READ_WAIT", n, 8);
      waitIdle("timeout", 100);
      checkOutput("timeout error cleared", 32'(consumer_error), 0);
      mem_never = 1'b0;
`endif

      checkOutput("mem queue drained", mem_exp_q.size(), 0);
      checkOutput("final busy", 32'(busy), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Shares one external data-memory port among NUM_CONSUMERS LSU-style requesters (one per thread).
- Each requester has independent read and write valid/ready channels, and the controller serves exactly one transaction at a time.
- Arbitration is round-robin. A 4-phase handshake runs on both the consumer side and the memory side.
- Sits between the per-thread LSUs of a core and the global data-memory interface.

Parameters:
- NUM_CONSUMERS, 4, number of requesters (≥2).
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.
- TIMEOUT_CYCLES, 64, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed read addresses; consumer i occupies slice i.
- consumer_read_ready  out  NUM_CONSUMERS  read-done acknowledge.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed returned data.
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed write addresses.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed write data.
- consumer_write_ready  out  NUM_CONSUMERS  write-done acknowledge.
- mem_read_valid  out  1  memory read request.
- mem_read_address  out  ADDR_BITS  memory read address.
- mem_read_ready  in  1  memory read complete.
- mem_read_data  in  DATA_BITS  memory read data.
- mem_write_valid  out  1  memory write request.
- mem_write_address  out  ADDR_BITS  memory write address.
- mem_write_data  out  DATA_BITS  memory write data.
- mem_write_ready  in  1  memory write complete.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered except busy, which is decoded from the state.
- Reset (reset=0, asynchronous): every output goes to 0, state=IDLE, rr_ptr=0, grant=0.
- Reset mid-transaction abandons the in-flight memory access. mem_*_valid drops immediately.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELEASE.
- IDLE:
  - A consumer is a candidate if its read_valid or write_valid is high.
  - Search order starts at rr_ptr and wraps modulo NUM_CONSUMERS.
  - The first candidate found becomes the grant g.
  - If g has both read and write pending, the read is served first.
  - Read grant: at the next edge, mem_read_valid←1, mem_read_address←slice g, state→READ_WAIT.
  - Write grant: mem_write_valid←1, address and data←slice g, state→WRITE_WAIT.
  - No candidate: stay in IDLE.
- READ_WAIT:
  - mem_read_valid and address are held stable until mem_read_ready=1.
  - On that edge: mem_read_valid←0, consumer_read_data slice g←mem_read_data, consumer_read_ready[g]←1, state→RELEASE.
- WRITE_WAIT:
  - Same as READ_WAIT, using mem_write_ready; consumer_write_ready[g]←1.
- RELEASE:
  - consumer_*_ready[g] stays high until the serviced valid of consumer g is sampled low.
  - On that edge: ready←0, rr_ptr←(g+1) mod NUM_CONSUMERS, state→IDLE.
- Latency: a request asserted before edge k drives memory valid after edge k. Ready reaches the consumer on the edge after memory ready. Minimum turnaround back to IDLE is 4 cycles with single-cycle memory.
- consumer_read_data slice g retains its value until the next read completes for g. Other slices never change while g is served.
- Only one of mem_read_valid and mem_write_valid is high at any time. Only one consumer ready bit is high at any time.
- Request changes by non-granted consumers during a transaction are ignored until IDLE.
- A consumer that drops valid before service is simply skipped. No request is latched.
- rr_ptr wraps from NUM_CONSUMERS-1 to 0.

Optional Feature:
- Macro: MEM_CONTROLLER_TIMEOUT_EN.
- When defined:
  - Adds output consumer_error (NUM_CONSUMERS).
  - A counter clears on entry to READ_WAIT/WRITE_WAIT and increments each cycle in those states.
  - When the counter reaches TIMEOUT_CYCLES-1 without memory ready, the transaction aborts: mem valid←0, read data slice←0, ready[g]←1, consumer_error[g]←1, state→RELEASE.
  - consumer_error[g] clears together with ready.
- When not defined: no port and no counter; the controller waits indefinitely for memory ready.

Decomposition:
- Package mem_controller_pkg holds the state enum type (2 bits: IDLE=0, READ_WAIT=1, WRITE_WAIT=2, RELEASE=3) and default width constants.
- Sub-module rr_arbiter (parameter N): combinational rotating-priority pick from request vector and pointer. Outputs grant index plus found flag.

Test Plan:
- Single read: consumer 2 reads addr 0x1A, memory returns 0x5C after 3 cycles -> one mem_read_valid burst with address 0x1A; consumer_read_data[2]=0x5C; consumer_read_ready[2] high until read_valid[2] drops; busy low afterwards.
- Round-robin: consumers 0, 1, 3 all request reads at once, rr_ptr=0 -> service order 0, 1, 3. Then consumer 0 re-requests while 1 pends -> order 1 then 0.
- Read+write same consumer: consumer 1 read 0x04 and write 0x08←0x77 together -> read done first, then write with mem_write_data=0x77; never both memory valids high.
- Wrap and hold: rr_ptr=3, consumer 3 writes, then all consumers request -> next grant is 0. Memory ready delayed 5 cycles -> address and data stable throughout.
- Async reset: reset low in READ_WAIT mid-cycle -> all outputs 0 without waiting for a clock edge; after release, a pending request from consumer 0 is served first.
- Timeout (with MEM_CONTROLLER_TIMEOUT_EN, TIMEOUT_CYCLES=8): memory never readies -> after 8 cycles in READ_WAIT, consumer_error[g]=1, ready[g]=1, data=0, then return to IDLE.
